// File: rtl/int_pkg.sv
// Shared types and constants for the peripheral interrupt controller.
package int_pkg;

    // Default number of interrupt sources wired into the controller.
    localparam int DEFAULT_NSRC = 8;

    // Upper bound on sources the controller is designed to handle.
    localparam int MAX_NSRC = 16;

    // Handshake states toward the CPU core.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2
    } int_state_t;

    // Source numbering for the timer/counter event lines.
    localparam int SRC_TC0_OCA = 0;
    localparam int SRC_TC0_OCB = 1;
    localparam int SRC_TC0_TOV = 2;
    localparam int SRC_TC1_OCA = 3;
    localparam int SRC_TC1_OCB = 4;
    localparam int SRC_TC1_TOV = 5;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder: index 0 has the highest priority.
module int_prio_enc #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic         any,
    output logic [W-1:0] idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        any = |req;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: latches source event pulses into pending flags,
// masks them with per-source and global enables, and runs a
// request/acknowledge handshake toward the CPU with a stable vector.
module int_ctrl
    import int_pkg::*;
#(
    parameter int NSRC  = DEFAULT_NSRC,
    parameter int VEC_W = $clog2(NSRC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NSRC-1:0]  src_pulse,
    input  logic [NSRC-1:0]  src_enable,
    input  logic             status_reg_interrupt_enable,
    input  logic             clr_valid,
    input  logic [NSRC-1:0]  clr_mask,
    output logic [NSRC-1:0]  pending,
    output logic             interrupt_request,
    output logic [VEC_W-1:0] vector,
    input  logic             interrupt_executed
);

    int_state_t       state_q, state_d;
    logic [NSRC-1:0]  pending_q, pending_d;
    logic [VEC_W-1:0] vector_q, vector_d;
    logic             exec_q;

    logic [NSRC-1:0]  eligible;
    logic             eligible_any;
    logic [VEC_W-1:0] eligible_idx;
    logic [NSRC-1:0]  vector_onehot;
    logic [NSRC-1:0]  sw_clear;
    logic [NSRC-1:0]  ack_clear;
    logic             ack;
    logic             ack_taken;
    logic             sw_withdraw;

    // Only a rising edge of the CPU acknowledge counts; exec_q starting
    // high keeps a level that is already high out of reset from counting.
    assign ack = interrupt_executed & ~exec_q;

    // Software clear is a write-1-to-clear mask qualified by its strobe.
    assign sw_clear = clr_valid ? clr_mask : '0;

    // One-hot form of the latched vector, used to retire its pending flag.
    assign vector_onehot = NSRC'(1) << vector_q;

    // A source can only be requested when both its own and the global enable are set.
    assign eligible = status_reg_interrupt_enable ? (pending_q & src_enable) : '0;

    // Software clearing the latched source withdraws the request, unless a
    // new pulse on that source lands in the same cycle and keeps it pending.
    assign sw_withdraw = sw_clear[vector_q] & ~src_pulse[vector_q];

    int_prio_enc #(
        .N (NSRC),
        .W (VEC_W)
    ) u_prio_enc (
        .req (eligible),
        .any (eligible_any),
        .idx (eligible_idx)
    );

    // Next-state and vector selection for the CPU handshake.
    always_comb begin
        state_d   = state_q;
        vector_d  = vector_q;
        ack_taken = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (eligible_any) begin
                    state_d  = REQ;
                    vector_d = eligible_idx;
                end
            end
            REQ: begin
                if (ack) begin
                    ack_taken = 1'b1;
                    state_d   = WAIT_LOW;
                end else if (!status_reg_interrupt_enable || sw_withdraw) begin
                    state_d = IDLE;
                end
            end
            WAIT_LOW: begin
                if (!interrupt_executed) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pending update: clears first, then new pulses, so a set always wins.
    always_comb begin
        ack_clear = ack_taken ? vector_onehot : '0;
        pending_d = (pending_q & ~(sw_clear | ack_clear)) | src_pulse;
    end

    // State, pending flags, vector and acknowledge history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            vector_q  <= '0;
            exec_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            vector_q  <= vector_d;
            exec_q    <= interrupt_executed;
        end
    end

    assign pending           = pending_q;
    assign vector            = vector_q;
    assign interrupt_request = (state_q == REQ);

endmodule

// File: tb/tb_int_ctrl.sv
// Directed testbench for int_ctrl: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_int_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] src_pulse;
    logic [7:0] src_enable;
    logic       status_reg_interrupt_enable;
    logic       clr_valid;
    logic [7:0] clr_mask;
    logic [7:0] pending;
    logic       interrupt_request;
    logic [2:0] vector;
    logic       interrupt_executed;

    int vecCount  = 0;
    int missCount = 0;

    int_ctrl #(
        .NSRC  (8),
        .VEC_W (3)
    ) dut (
        .clk                         (clk),
        .rst                         (rst),
        .src_pulse                   (src_pulse),
        .src_enable                  (src_enable),
        .status_reg_interrupt_enable (status_reg_interrupt_enable),
        .clr_valid                   (clr_valid),
        .clr_mask                    (clr_mask),
        .pending                     (pending),
        .interrupt_request           (interrupt_request),
        .vector                      (vector),
        .interrupt_executed          (interrupt_executed)
    );

    // 10-unit free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs while reset is held and just after release.
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vecCount++;
        if ({interrupt_request, vector, pending} !== {1'b0, 3'd0, 8'h00}) begin
            missCount++;
            $display("[TB] FAIL reset_hold: got req=%b vec=%0d pend=%h, want req=0 vec=0 pend=00", interrupt_request, vector, pending);
        end
        rst = 1'b0;
        tick();
        vecCount++;
        if ({interrupt_request, vector, pending} !== {1'b0, 3'd0, 8'h00}) begin
            missCount++;
            $display("[TB] FAIL reset_release: got req=%b vec=%0d pend=%h, want req=0 vec=0 pend=00", interrupt_request, vector, pending);
        end
    endtask

    // Single source through the full handshake.
    task automatic test_basic();
        src_enable = 8'h04;
        status_reg_interrupt_enable = 1'b1;
        src_pulse = 8'h04;
        tick();
        src_pulse = 8'h00;
        vecCount++;
        if ({interrupt_request, pending} !== {1'b0, 8'h04}) begin
            missCount++;
            $display("[TB] FAIL basic_pending: got req=%b pend=%h, want req=0 pend=04", interrupt_request, pending);
        end
        tick();
        vecCount++;
        if ({interrupt_request, vector} !== {1'b1, 3'd2}) begin
            missCount++;
            $display("[TB] FAIL basic_request: got req=%b vec=%0d, want req=1 vec=2", interrupt_request, vector);
        end
        interrupt_executed = 1'b1;
        tick();
        vecCount++;
        if ({interrupt_request, vector, pending} !== {1'b0, 3'd2, 8'h00}) begin
            missCount++;
            $display("[TB] FAIL basic_ack: got req=%b vec=%0d pend=%h, want req=0 vec=2 pend=00", interrupt_request, vector, pending);
        end
        interrupt_executed = 1'b0;
        tick();
        tick();
        vecCount++;
        if (interrupt_request !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL basic_idle: got req=%b, want req=0", interrupt_request);
        end
    endtask

    // Three simultaneous sources serviced lowest index first.
    task automatic test_priority();
        logic [2:0] expVec [3];
        logic [7:0] expPend [3];
        expVec[0] = 3'd1; expPend[0] = 8'h28;
        expVec[1] = 3'd3; expPend[1] = 8'h20;
        expVec[2] = 3'd5; expPend[2] = 8'h00;
        src_enable = 8'h3F;
        src_pulse = 8'h2A;
        tick();
        src_pulse = 8'h00;
        vecCount++;
        if (pending !== 8'h2A) begin
            missCount++;
            $display("[TB] FAIL prio_latch: got pend=%h, want pend=2a", pending);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            vecCount++;
            if ({interrupt_request, vector} !== {1'b1, expVec[i]}) begin
                missCount++;
                $display("[TB] FAIL prio_req%0d: got req=%b vec=%0d, want req=1 vec=%0d", i, interrupt_request, vector, expVec[i]);
            end
            interrupt_executed = 1'b1;
            tick();
            vecCount++;
            if ({interrupt_request, pending} !== {1'b0, expPend[i]}) begin
                missCount++;
                $display("[TB] FAIL prio_ack%0d: got req=%b pend=%h, want req=0 pend=%h", i, interrupt_request, pending, expPend[i]);
            end
            interrupt_executed = 1'b0;
            tick();
            tick();
        end
        vecCount++;
        if (interrupt_request !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL prio_done: got req=%b, want req=0", interrupt_request);
        end
    endtask

    // Per-source mask, then global mask, then software clear.
    task automatic test_masking();
        src_enable = 8'h00;
        src_pulse = 8'h10;
        tick();
        src_pulse = 8'h00;
        tick();
        tick();
        vecCount++;
        if ({interrupt_request, pending} !== {1'b0, 8'h10}) begin
            missCount++;
            $display("[TB] FAIL mask_src: got req=%b pend=%h, want req=0 pend=10", interrupt_request, pending);
        end
        src_enable = 8'h10;
        tick();
        vecCount++;
        if ({interrupt_request, vector} !== {1'b1, 3'd4}) begin
            missCount++;
            $display("[TB] FAIL mask_enable: got req=%b vec=%0d, want req=1 vec=4", interrupt_request, vector);
        end
        status_reg_interrupt_enable = 1'b0;
        tick();
        tick();
        vecCount++;
        if ({interrupt_request, pending} !== {1'b0, 8'h10}) begin
            missCount++;
            $display("[TB] FAIL mask_global: got req=%b pend=%h, want req=0 pend=10", interrupt_request, pending);
        end
        clr_valid = 1'b1;
        clr_mask = 8'h10;
        tick();
        clr_valid = 1'b0;
        clr_mask = 8'h00;
        vecCount++;
        if (pending !== 8'h00) begin
            missCount++;
            $display("[TB] FAIL mask_clear: got pend=%h, want pend=00", pending);
        end
        status_reg_interrupt_enable = 1'b1;
        tick();
        vecCount++;
        if (interrupt_request !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL mask_cleared_idle: got req=%b, want req=0", interrupt_request);
        end
    endtask

    // Withdraw by global enable and by software clear of the latched source.
    task automatic test_withdraw();
        src_enable = 8'h01;
        src_pulse = 8'h01;
        tick();
        src_pulse = 8'h00;
        tick();
        vecCount++;
        if ({interrupt_request, vector} !== {1'b1, 3'd0}) begin
            missCount++;
            $display("[TB] FAIL wd_req: got req=%b vec=%0d, want req=1 vec=0", interrupt_request, vector);
        end
        status_reg_interrupt_enable = 1'b0;
        tick();
        vecCount++;
        if ({interrupt_request, pending} !== {1'b0, 8'h01}) begin
            missCount++;
            $display("[TB] FAIL wd_global: got req=%b pend=%h, want req=0 pend=01", interrupt_request, pending);
        end
        status_reg_interrupt_enable = 1'b1;
        tick();
        vecCount++;
        if ({interrupt_request, vector} !== {1'b1, 3'd0}) begin
            missCount++;
            $display("[TB] FAIL wd_rerequest: got req=%b vec=%0d, want req=1 vec=0", interrupt_request, vector);
        end
        clr_valid = 1'b1;
        clr_mask = 8'h01;
        tick();
        clr_valid = 1'b0;
        clr_mask = 8'h00;
        vecCount++;
        if ({interrupt_request, pending} !== {1'b0, 8'h00}) begin
            missCount++;
            $display("[TB] FAIL wd_swclear: got req=%b pend=%h, want req=0 pend=00", interrupt_request, pending);
        end
        tick();
        vecCount++;
        if (interrupt_request !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL wd_stay_idle: got req=%b, want req=0", interrupt_request);
        end
    endtask

    // Higher-priority arrival and enable drop do not disturb a live request.
    task automatic test_no_preempt();
        src_enable = 8'h05;
        src_pulse = 8'h04;
        tick();
        src_pulse = 8'h00;
        tick();
        src_pulse = 8'h01;
        tick();
        src_pulse = 8'h00;
        src_enable = 8'h01;
        tick();
        vecCount++;
        if ({interrupt_request, vector, pending} !== {1'b1, 3'd2, 8'h05}) begin
            missCount++;
            $display("[TB] FAIL np_hold: got req=%b vec=%0d pend=%h, want req=1 vec=2 pend=05", interrupt_request, vector, pending);
        end
        src_enable = 8'h05;
        interrupt_executed = 1'b1;
        tick();
        vecCount++;
        if ({interrupt_request, pending} !== {1'b0, 8'h01}) begin
            missCount++;
            $display("[TB] FAIL np_ack: got req=%b pend=%h, want req=0 pend=01", interrupt_request, pending);
        end
        interrupt_executed = 1'b0;
        tick();
        tick();
        vecCount++;
        if ({interrupt_request, vector} !== {1'b1, 3'd0}) begin
            missCount++;
            $display("[TB] FAIL np_next: got req=%b vec=%0d, want req=1 vec=0", interrupt_request, vector);
        end
        interrupt_executed = 1'b1;
        tick();
        interrupt_executed = 1'b0;
        tick();
        tick();
    endtask

    // Set and clear of the same flag in one cycle: the set wins.
    task automatic test_collision();
        src_enable = 8'h04;
        src_pulse = 8'h04;
        tick();
        src_pulse = 8'h00;
        tick();
        interrupt_executed = 1'b1;
        src_pulse = 8'h04;
        tick();
        src_pulse = 8'h00;
        vecCount++;
        if ({interrupt_request, pending} !== {1'b0, 8'h04}) begin
            missCount++;
            $display("[TB] FAIL col_ack_set: got req=%b pend=%h, want req=0 pend=04", interrupt_request, pending);
        end
        interrupt_executed = 1'b0;
        tick();
        tick();
        vecCount++;
        if ({interrupt_request, vector} !== {1'b1, 3'd2}) begin
            missCount++;
            $display("[TB] FAIL col_second_req: got req=%b vec=%0d, want req=1 vec=2", interrupt_request, vector);
        end
        interrupt_executed = 1'b1;
        tick();
        interrupt_executed = 1'b0;
        tick();
        tick();
        src_enable = 8'h00;
        clr_valid = 1'b1;
        clr_mask = 8'h01;
        src_pulse = 8'h01;
        tick();
        clr_valid = 1'b0;
        clr_mask = 8'h00;
        src_pulse = 8'h00;
        vecCount++;
        if (pending !== 8'h01) begin
            missCount++;
            $display("[TB] FAIL col_clr_set: got pend=%h, want pend=01", pending);
        end
        clr_valid = 1'b1;
        clr_mask = 8'h01;
        tick();
        clr_valid = 1'b0;
        clr_mask = 8'h00;
        vecCount++;
        if (pending !== 8'h00) begin
            missCount++;
            $display("[TB] FAIL col_clr_only: got pend=%h, want pend=00", pending);
        end
    endtask

    // Reset in the middle of a handshake with the acknowledge held high.
    task automatic test_reset_mid();
        src_enable = 8'h08;
        src_pulse = 8'h08;
        tick();
        src_pulse = 8'h00;
        tick();
        interrupt_executed = 1'b1;
        rst = 1'b1;
        #1;
        vecCount++;
        if ({interrupt_request, vector, pending} !== {1'b0, 3'd0, 8'h00}) begin
            missCount++;
            $display("[TB] FAIL rst_mid: got req=%b vec=%0d pend=%h, want req=0 vec=0 pend=00", interrupt_request, vector, pending);
        end
        tick();
        rst = 1'b0;
        tick();
        src_pulse = 8'h08;
        tick();
        src_pulse = 8'h00;
        tick();
        tick();
        vecCount++;
        if ({interrupt_request, vector, pending} !== {1'b1, 3'd3, 8'h08}) begin
            missCount++;
            $display("[TB] FAIL rst_no_spurious_ack: got req=%b vec=%0d pend=%h, want req=1 vec=3 pend=08", interrupt_request, vector, pending);
        end
        interrupt_executed = 1'b0;
        tick();
        interrupt_executed = 1'b1;
        tick();
        vecCount++;
        if ({interrupt_request, pending} !== {1'b0, 8'h00}) begin
            missCount++;
            $display("[TB] FAIL rst_serviced: got req=%b pend=%h, want req=0 pend=00", interrupt_request, pending);
        end
        interrupt_executed = 1'b0;
        tick();
        tick();
    endtask

    // Scenario sequence and summary.
    initial begin
        rst = 1'b1;
        src_pulse = 8'h00;
        src_enable = 8'h00;
        status_reg_interrupt_enable = 1'b0;
        clr_valid = 1'b0;
        clr_mask = 8'h00;
        interrupt_executed = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_masking();
        test_withdraw();
        test_no_preempt();
        test_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
